// File: rtl/serv_pkg.sv
// Shared constants and helpers for the bit-serial SERV PC datapath.
// Chunk geometry is derived from the per-instance serial width W.
package serv_pkg;

  localparam int XLEN = 32;

  function automatic int chunks(input int w);
    return XLEN / w;
  endfunction

  function automatic int cnt_width(input int w);
    return (XLEN / w > 1) ? $clog2(XLEN / w) : 1;
  endfunction

  // Chunk k of a constant addend: (v >> k*w), truncated to w bits.
  function automatic logic [7:0] const_chunk(
    input logic [31:0] v,
    input int          k,
    input int          w
  );
    return 8'(v >> (k * w)) & 8'((1 << w) - 1);
  endfunction

endpackage

// File: rtl/serv_ser_add.sv
// W-bit serial adder slice with a registered carry between chunks.
// Carry-in is forced to zero on the first chunk of a pass.
module serv_ser_add #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_q
);

  logic       c_r;
  logic [W:0] sum;

  assign sum = {1'b0, i_a} + {1'b0, i_b}
             + {{W{1'b0}}, c_r & ~i_clr};
  assign o_q = sum[W-1:0];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      c_r <= 1'b0;
    end else if (i_en) begin
      c_r <= sum[W];
    end
  end

endmodule

// File: rtl/serv_pc_unit.sv
// W-bit serial PC unit: next PC, prefetch address, rd data, misalign flag.
// SERV_PC_COMPRESSED_EN enables 16-bit increments and 2-byte targets.
module serv_pc_unit
  import serv_pkg::*;
#(
  parameter int          W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_pc_en,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic         i_iscomp,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic         o_bad_pc,
  output logic         o_busy,
  output logic         o_done,
  output logic [31:0]  o_ibus_adr,
  output logic [31:0]  o_ibus_nxtadr
);

  localparam int N     = chunks(W);
  localparam int CNT_W = cnt_width(W);
  // Absolute bit 1 lives in chunk 1 for W=1, else bit 1 of chunk 0.
  localparam int BAD_K = (W == 1) ? 1 : 0;
  localparam int BAD_B = (W == 1) ? 0 : 1;

  logic [CNT_W-1:0] k;
  logic             first;
  logic             last;
  logic             bad_r;
  logic             bad_hit;
  logic [31:0]      inc_full;

  logic [W-1:0] pc;
  logic [W-1:0] inc_c;
  logic [W-1:0] four_c;
  logic [W-1:0] pc_plus_inc;
  logic [W-1:0] off_a;
  logic [W-1:0] off_b;
  logic [W-1:0] off_sum;
  logic [W-1:0] aligned;
  logic [W-1:0] csr_c;
  logic [W-1:0] new_c;
  logic [W-1:0] nxt_c;
  logic [W-1:0] umask;

  assign first = (k == '0);
  assign last  = (k == CNT_W'(N - 1));
  assign pc    = o_ibus_adr[W-1:0];

`ifdef SERV_PC_COMPRESSED_EN
  assign inc_full = i_iscomp ? 32'd2 : 32'd4;
  assign bad_hit  = 1'b0;
`else
  logic unused_iscomp;
  assign unused_iscomp = i_iscomp;
  assign inc_full      = 32'd4;
  assign bad_hit       = i_jump & ~i_trap & aligned[BAD_B];
`endif

  assign inc_c  = W'(const_chunk(inc_full, int'(k), W));
  assign four_c = W'(const_chunk(32'd4, int'(k), W));

  always_comb begin
    umask = '0;
    for (int j = 0; j < W; j++) begin
      umask[j] = (int'(k) * W + j) >= 12;
    end
  end

  assign off_a = i_pc_rel ? pc : '0;
  assign off_b = i_utype ? (i_imm & umask) : i_buf;

  always_comb begin
    aligned = off_sum;
    csr_c   = i_csr_pc;
    if (first) begin
      aligned[0] = 1'b0;
      csr_c[0]   = 1'b0;
    end
  end

  assign new_c = i_trap ? csr_c
               : i_jump ? aligned
               : pc_plus_inc;

  assign o_rd = (i_utype ? aligned : '0)
              | (i_jal_or_jalr ? pc_plus_inc : '0);

  assign o_busy = (k != '0);
  assign o_done = i_rst_n & i_pc_en & last;

  serv_ser_add #(.W(W)) u_inc (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pc_en),
    .i_clr   (first),
    .i_a     (pc),
    .i_b     (inc_c),
    .o_q     (pc_plus_inc)
  );

  serv_ser_add #(.W(W)) u_off (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pc_en),
    .i_clr   (first),
    .i_a     (off_a),
    .i_b     (off_b),
    .o_q     (off_sum)
  );

  serv_ser_add #(.W(W)) u_nxt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pc_en),
    .i_clr   (first),
    .i_a     (new_c),
    .i_b     (four_c),
    .o_q     (nxt_c)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      k             <= '0;
      o_ibus_adr    <= RESET_PC;
      o_ibus_nxtadr <= RESET_PC + 32'd4;
      bad_r         <= 1'b0;
      o_bad_pc      <= 1'b0;
    end else if (i_pc_en) begin
      k             <= k + CNT_W'(1);
      o_ibus_adr    <= {new_c, o_ibus_adr[31:W]};
      o_ibus_nxtadr <= {nxt_c, o_ibus_nxtadr[31:W]};
      if (k == CNT_W'(BAD_K)) begin
        bad_r <= bad_hit;
      end
      if (last) begin
        o_bad_pc <= bad_r;
      end
    end
  end

endmodule

// File: tb/tb_serv_pc_unit.sv
// Directed bench for serv_pc_unit across W = 1, 2, 4 and 8.
// Each instance is driven from shared controls and shifted data vectors.
module tb_serv_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en [4];
  logic        jump, jal, utype, pcrel, trap, iscomp;
  logic [31:0] imm_v, buf_v, csr_v;
  logic [31:0] imm_sh, buf_sh, csr_sh;

  logic [0:0]  rd1;
  logic [1:0]  rd2;
  logic [3:0]  rd4;
  logic [7:0]  rd8;
  logic        bad [4];
  logic        busy [4];
  logic        done [4];
  logic [31:0] adr [4];
  logic [31:0] nxt [4];

  int vecs = 0;
  int errs = 0;

  serv_pc_unit #(.W(1), .RESET_PC(32'h200)) u1 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(en[0]), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel),
    .i_trap(trap), .i_iscomp(iscomp), .i_imm(imm_sh[0:0]),
    .i_buf(buf_sh[0:0]), .i_csr_pc(csr_sh[0:0]), .o_rd(rd1),
    .o_bad_pc(bad[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_ibus_adr(adr[0]), .o_ibus_nxtadr(nxt[0]));

  serv_pc_unit #(.W(2), .RESET_PC(32'h1000)) u2 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(en[1]), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel),
    .i_trap(trap), .i_iscomp(iscomp), .i_imm(imm_sh[1:0]),
    .i_buf(buf_sh[1:0]), .i_csr_pc(csr_sh[1:0]), .o_rd(rd2),
    .o_bad_pc(bad[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_ibus_adr(adr[1]), .o_ibus_nxtadr(nxt[1]));

  serv_pc_unit #(.W(4), .RESET_PC(32'h100)) u4 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(en[2]), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel),
    .i_trap(trap), .i_iscomp(iscomp), .i_imm(imm_sh[3:0]),
    .i_buf(buf_sh[3:0]), .i_csr_pc(csr_sh[3:0]), .o_rd(rd4),
    .o_bad_pc(bad[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_ibus_adr(adr[2]), .o_ibus_nxtadr(nxt[2]));

  serv_pc_unit #(.W(8), .RESET_PC(32'h0)) u8 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(en[3]), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel),
    .i_trap(trap), .i_iscomp(iscomp), .i_imm(imm_sh[7:0]),
    .i_buf(buf_sh[7:0]), .i_csr_pc(csr_sh[7:0]), .o_rd(rd8),
    .o_bad_pc(bad[3]), .o_busy(busy[3]), .o_done(done[3]),
    .o_ibus_adr(adr[3]), .o_ibus_nxtadr(nxt[3]));

  function automatic logic [31:0] get_rd(input int sel);
    case (sel)
      0: return 32'(rd1);
      1: return 32'(rd2);
      2: return 32'(rd4);
      default: return 32'(rd8);
    endcase
  endfunction

  task automatic set_ctrl(input logic j, input logic l, input logic u,
                          input logic p, input logic t, input logic c);
    jump = j; jal = l; utype = u; pcrel = p; trap = t; iscomp = c;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int j = 0; j < 4; j++) en[j] = 1'b0;
    set_ctrl(0, 0, 0, 0, 0, 0);
    imm_v = '0; buf_v = '0; csr_v = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one pass on instance sel; optional stall, mid-pass reset, no-bubble exit.
  task automatic run_pass(input int sel, input int stall_at,
                          input int stall_len, input int rst_at,
                          input bit keep, output logic [31:0] rd_acc,
                          output logic [31:0] done_mask,
                          output int stall_bad);
    int w, n;
    w = 1 << sel;
    n = 32 / w;
    rd_acc = '0; done_mask = '0; stall_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk);
          for (int j = 0; j < 4; j++) en[j] = 1'b0;
          imm_sh = 32'hDEADBEEF; buf_sh = 32'hCAFEF00D; csr_sh = 32'h5A5A5A5A;
          #1;
          if (done[sel] !== 1'b0 || busy[sel] !== 1'b1) stall_bad++;
        end
      end
      @(negedge clk);
      for (int j = 0; j < 4; j++) en[j] = (j == sel);
      imm_sh = imm_v >> (i * w);
      buf_sh = buf_v >> (i * w);
      csr_sh = csr_v >> (i * w);
      if (i == rst_at) rst_n = 1'b0;
      #1;
      rd_acc |= get_rd(sel) << (i * w);
      if (done[sel] === 1'b1) done_mask[i] = 1'b1;
      if (i == rst_at) begin
        @(negedge clk);
        for (int j = 0; j < 4; j++) en[j] = 1'b0;
        rst_n = 1'b1;
        return;
      end
    end
    if (!keep) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) en[j] = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vecs++; if (adr[2] !== 32'h100) begin errs++; $display("FAIL rst_adr got=%h exp=%h", adr[2], 32'h100); end
    vecs++; if (nxt[2] !== 32'h104) begin errs++; $display("FAIL rst_nxt got=%h exp=%h", nxt[2], 32'h104); end
    vecs++; if (bad[2] !== 1'b0) begin errs++; $display("FAIL rst_bad got=%b exp=0", bad[2]); end
    vecs++; if (busy[2] !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy[2]); end
    vecs++; if (done[2] !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", done[2]); end
    vecs++; if (nxt[3] !== 32'h4) begin errs++; $display("FAIL rst_nxt_w8 got=%h exp=%h", nxt[3], 32'h4); end
  endtask

  task automatic test_sequential();
    logic [31:0] rd, dm; int sb;
    apply_reset();
    run_pass(2, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (dm !== 32'h80) begin errs++; $display("FAIL seq_done got=%h exp=%h", dm, 32'h80); end
    vecs++; if (adr[2] !== 32'h104) begin errs++; $display("FAIL seq_adr got=%h exp=%h", adr[2], 32'h104); end
    vecs++; if (nxt[2] !== 32'h108) begin errs++; $display("FAIL seq_nxt got=%h exp=%h", nxt[2], 32'h108); end
    vecs++; if (busy[2] !== 1'b0) begin errs++; $display("FAIL seq_busy got=%b exp=0", busy[2]); end
    vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL seq_rd got=%h exp=0", rd); end
  endtask

  task automatic test_compressed();
    logic [31:0] rd, dm, e; int sb;
`ifdef SERV_PC_COMPRESSED_EN
    e = 32'h102;
`else
    e = 32'h104;
`endif
    apply_reset();
    set_ctrl(0, 0, 0, 0, 0, 1);
    run_pass(2, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (adr[2] !== e) begin errs++; $display("FAIL comp_adr got=%h exp=%h", adr[2], e); end
    vecs++; if (nxt[2] !== e + 32'd4) begin errs++; $display("FAIL comp_nxt got=%h exp=%h", nxt[2], e + 32'd4); end
  endtask

  task automatic test_jal();
    logic [31:0] rd, dm; int sb;
    apply_reset();
    set_ctrl(1, 1, 0, 0, 0, 0);
    buf_v = 32'h240;
    run_pass(0, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (rd !== 32'h204) begin errs++; $display("FAIL jal_rd got=%h exp=%h", rd, 32'h204); end
    vecs++; if (adr[0] !== 32'h240) begin errs++; $display("FAIL jal_adr got=%h exp=%h", adr[0], 32'h240); end
    vecs++; if (nxt[0] !== 32'h244) begin errs++; $display("FAIL jal_nxt got=%h exp=%h", nxt[0], 32'h244); end
    vecs++; if (dm !== 32'h80000000) begin errs++; $display("FAIL jal_done got=%h exp=%h", dm, 32'h80000000); end
    vecs++; if (bad[0] !== 1'b0) begin errs++; $display("FAIL jal_bad got=%b exp=0", bad[0]); end
  endtask

  task automatic test_auipc();
    logic [31:0] rd, dm; int sb;
    apply_reset();
    set_ctrl(0, 0, 1, 1, 0, 0);
    imm_v = 32'h12345FFF;
    run_pass(1, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (rd !== 32'h12346000) begin errs++; $display("FAIL auipc_rd got=%h exp=%h", rd, 32'h12346000); end
    vecs++; if (adr[1] !== 32'h1004) begin errs++; $display("FAIL auipc_adr got=%h exp=%h", adr[1], 32'h1004); end
    vecs++; if (nxt[1] !== 32'h1008) begin errs++; $display("FAIL auipc_nxt got=%h exp=%h", nxt[1], 32'h1008); end
  endtask

  task automatic test_trap();
    logic [31:0] rd, dm; int sb;
    apply_reset();
    set_ctrl(0, 0, 0, 0, 1, 0);
    csr_v = 32'h80000003;
    run_pass(2, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (adr[2] !== 32'h80000002) begin errs++; $display("FAIL trap_adr got=%h exp=%h", adr[2], 32'h80000002); end
    vecs++; if (nxt[2] !== 32'h80000006) begin errs++; $display("FAIL trap_nxt got=%h exp=%h", nxt[2], 32'h80000006); end
    vecs++; if (bad[2] !== 1'b0) begin errs++; $display("FAIL trap_bad got=%b exp=0", bad[2]); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, dm; int sb; logic eb;
`ifdef SERV_PC_COMPRESSED_EN
    eb = 1'b0;
`else
    eb = 1'b1;
`endif
    apply_reset();
    set_ctrl(1, 0, 0, 0, 0, 0);
    buf_v = 32'h302;
    run_pass(2, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (bad[2] !== eb) begin errs++; $display("FAIL mis_bad got=%b exp=%b", bad[2], eb); end
    vecs++; if (adr[2] !== 32'h302) begin errs++; $display("FAIL mis_adr got=%h exp=%h", adr[2], 32'h302); end
    vecs++; if (nxt[2] !== 32'h306) begin errs++; $display("FAIL mis_nxt got=%h exp=%h", nxt[2], 32'h306); end
    set_ctrl(0, 0, 0, 0, 0, 0);
    run_pass(2, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (bad[2] !== 1'b0) begin errs++; $display("FAIL mis_clear got=%b exp=0", bad[2]); end
    vecs++; if (adr[2] !== 32'h306) begin errs++; $display("FAIL mis_seq got=%h exp=%h", adr[2], 32'h306); end
  endtask

  task automatic test_stall();
    logic [31:0] rd, dm; int sb;
    apply_reset();
    set_ctrl(1, 0, 0, 0, 0, 0);
    buf_v = 32'h12345678;
    run_pass(3, 2, 3, -1, 0, rd, dm, sb);
    vecs++; if (sb !== 0) begin errs++; $display("FAIL stall_hold got=%0d exp=0", sb); end
    vecs++; if (adr[3] !== 32'h12345678) begin errs++; $display("FAIL stall_adr got=%h exp=%h", adr[3], 32'h12345678); end
    vecs++; if (nxt[3] !== 32'h1234567C) begin errs++; $display("FAIL stall_nxt got=%h exp=%h", nxt[3], 32'h1234567C); end
    vecs++; if (dm !== 32'h8) begin errs++; $display("FAIL stall_done got=%h exp=%h", dm, 32'h8); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, dm; int sb;
    set_ctrl(1, 0, 0, 0, 0, 0);
    buf_v = 32'hABCD0000;
    run_pass(3, -1, 0, -1, 1, rd, dm, sb);
    @(posedge clk);
    #1;
    vecs++; if (adr[3] !== 32'hABCD0000) begin errs++; $display("FAIL b2b_adr1 got=%h exp=%h", adr[3], 32'hABCD0000); end
    vecs++; if (busy[3] !== 1'b0) begin errs++; $display("FAIL b2b_busy got=%b exp=0", busy[3]); end
    set_ctrl(0, 0, 0, 0, 0, 0);
    run_pass(3, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (adr[3] !== 32'hABCD0004) begin errs++; $display("FAIL b2b_adr2 got=%h exp=%h", adr[3], 32'hABCD0004); end
    vecs++; if (nxt[3] !== 32'hABCD0008) begin errs++; $display("FAIL b2b_nxt got=%h exp=%h", nxt[3], 32'hABCD0008); end
    vecs++; if (dm !== 32'h8) begin errs++; $display("FAIL b2b_done got=%h exp=%h", dm, 32'h8); end
  endtask

  task automatic test_reset_midpass();
    logic [31:0] rd, dm; int sb;
    apply_reset();
    set_ctrl(1, 0, 0, 0, 0, 0);
    buf_v = 32'h302;
    run_pass(2, -1, 0, 2, 0, rd, dm, sb);
    #1;
    vecs++; if (adr[2] !== 32'h100) begin errs++; $display("FAIL mrst_adr got=%h exp=%h", adr[2], 32'h100); end
    vecs++; if (nxt[2] !== 32'h104) begin errs++; $display("FAIL mrst_nxt got=%h exp=%h", nxt[2], 32'h104); end
    vecs++; if (busy[2] !== 1'b0) begin errs++; $display("FAIL mrst_busy got=%b exp=0", busy[2]); end
    vecs++; if (dm !== 32'h0) begin errs++; $display("FAIL mrst_done got=%h exp=0", dm); end
    set_ctrl(0, 0, 0, 0, 0, 0);
    run_pass(2, -1, 0, -1, 0, rd, dm, sb);
    vecs++; if (adr[2] !== 32'h104) begin errs++; $display("FAIL mrst_resume got=%h exp=%h", adr[2], 32'h104); end
    vecs++; if (bad[2] !== 1'b0) begin errs++; $display("FAIL mrst_bad got=%b exp=0", bad[2]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int j = 0; j < 4; j++) en[j] = 1'b0;
    set_ctrl(0, 0, 0, 0, 0, 0);
    imm_v = '0; buf_v = '0; csr_v = '0;
    imm_sh = '0; buf_sh = '0; csr_sh = '0;
    test_reset();
    test_sequential();
    test_compressed();
    test_jal();
    test_auipc();
    test_trap();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_midpass();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serv_pc_unit.md
# serv_pc_unit

Parametrised bit-serial program-counter unit for the SERV core family. It generalises the core's 1-bit PC datapath to a W-bit-per-cycle (1/2/4/8) serial datapath and tracks its own chunk counter. It can stall mid-pass and computes both the new PC and its sequential successor in one pass. It also reports a registered misaligned-target flag. It sits between decode/state and the instruction bus and drives the ibus address and the rd write data for JAL/JALR/AUIPC/LUI.

## Interface
- W, 1, bits processed per cycle; legal values 1, 2, 4, 8.
- RESET_PC, 32'd0, PC value loaded on reset.
- clk  in  1  core clock; all state on rising edge.
- i_rst_n  in  1  synchronous reset, active low.
- i_pc_en  in  1  advance one chunk of the update pass this cycle.
- i_jump  in  1  select branch/jump target.
- i_jal_or_jalr  in  1  rd = PC + inc.
- i_utype  in  1  AUIPC/LUI; rd = offset sum.
- i_pc_rel  in  1  offset adder uses PC (AUIPC, branches, JAL).
- i_trap  in  1  select trap vector from i_csr_pc.
- i_iscomp  in  1  current instruction is 16-bit; inc = 2, else 4.
- i_imm  in  W  immediate chunk, LSB-first.
- i_buf  in  W  rs1+imm or PC-offset chunk from buffer, LSB-first.
- i_csr_pc  in  W  mtvec/mepc chunk, LSB-first.
- o_rd  out  W  rd data chunk for the current cycle.
- o_bad_pc  out  1  registered: last jump target misaligned.
- o_busy  out  1  pass in progress (chunk counter ≠ 0).
- o_done  out  1  final chunk processed this cycle.
- o_ibus_adr  out  32  current PC.
- o_ibus_nxtadr  out  32  new PC + 4, prefetch address.

## Operation
- N = 32/W chunks per pass. k = internal chunk counter, 0..N-1, width clog2(N) (min 1). k increments on i_pc_en and wraps N-1→0.
- Chunk k covers bits [k*W +: W]. pc = o_ibus_adr[W-1:0]. o_ibus_adr shifts right by W per enabled cycle, new chunk inserted at the top.
- inc chunk = ((i_iscomp ? 2 : 4) >> k*W) truncated to W.
- Adder 1: pc + inc + c4. Gives pc_plus_inc and carry c4.
- Offset adder: a = i_pc_rel ? pc : 0. b = i_utype ? (i_imm with bits below absolute position 12 masked) : i_buf. Sum carries via co.
- aligned = offset sum with absolute bit 0 forced to 0.
- new chunk = i_trap ? (i_csr_pc, bit 0 forced 0) : i_jump ? aligned : pc_plus_inc.
- o_rd = (i_utype ? aligned : 0) | (i_jal_or_jalr ? pc_plus_inc : 0).
- Adder 2: new + (4 >> k*W) + cn. Shifted into nxtadr register the same way as o_ibus_adr.
- Carries c4, co, cn are cleared when k==0 and i_pc_en; otherwise they are updated from this cycle's carry-out.
- Misalignment, evaluated on the chunk holding absolute bit 1 when i_jump && !i_trap: bad = aligned bit 1 (compressed support out). Compressed support in: bad = 0.
- bad is latched into o_bad_pc at o_done. The PC is still updated; trap sequencing is the state machine's job.

## Timing
- Reset values: o_ibus_adr = RESET_PC; o_ibus_nxtadr = RESET_PC + 4; o_bad_pc = 0; k = 0; carries = 0; o_busy = 0; o_done = 0.
- o_done is combinational: i_pc_en && k==N-1.
- The new PC and nxtadr are valid on the cycle after o_done. Latency is N enabled cycles.
- o_ibus_adr and o_ibus_nxtadr hold rotated, partial values while o_busy. Consumers sample only when !o_busy.
- Stall: i_pc_en low mid-pass holds k, carries and shift registers exactly. Resume continues at the same chunk.
- Control inputs must be stable for the whole pass. Data chunks are valid only on enabled cycles.
- Reset asserted mid-pass dominates i_pc_en and restores all reset values.
- Back-to-back passes: k wraps to 0 and the next pass may start on the following cycle with no bubble.

## Configuration
- SERV_PC_COMPRESSED_EN defined:
  - i_iscomp honoured.
  - 2-byte targets legal; o_bad_pc is held 0.
- SERV_PC_COMPRESSED_EN undefined:
  - i_iscomp ignored; inc is always 4.
  - A jump target with bit 1 set raises o_bad_pc.

## Structure
- Shared package serv_pkg holds:
  - localparams N = 32/W and CNT_W = clog2(N);
  - a function returning the constant-addend chunk (value >> k*W, truncated to W).
- Sub-module serv_ser_add: W-bit serial adder with registered carry, clear and enable. Instantiated three times (inc, offset, nxtadr).

## Test plan
- Reset with RESET_PC=0x100, W=4 -> o_ibus_adr=0x100, nxtadr=0x104, o_bad_pc=0, o_busy=0.
- Sequential: 8 enabled cycles, no jump, W=4, PC=0x100 -> o_done on cycle 8; then PC=0x104, nxtadr=0x108.
- JAL, W=1, PC=0x200, i_buf serialises 0x240, i_jal_or_jalr=1 -> PC=0x240; o_rd stream = 0x204; nxtadr=0x244.
- AUIPC, W=2, PC=0x1000, imm=0x12345FFF -> o_rd stream = 0x12346000; PC=0x1004.
- Trap with i_csr_pc=0x80000003 -> PC=0x80000002. Jump to 0x302 with macro undefined -> o_bad_pc=1 after o_done; with macro defined -> 0.
- Stall/reset: W=8, i_pc_en low for 3 cycles after chunk 1 -> same result as unstalled. i_rst_n low at chunk 2 -> all reset values next cycle.
